// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the board-level reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_e;

    localparam logic [1:0] CAUSE_POWER     = 2'd0;
    localparam logic [1:0] CAUSE_LOCK_LOSS = 2'd1;
    localparam logic [1:0] CAUSE_WDT       = 2'd2;
    localparam logic [1:0] CAUSE_SW        = 2'd3;

    localparam int unsigned RESET_COUNT_W = 8;

endpackage

// File: rtl/reset_seq_lock_sync.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module reset_seq_lock_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_DOMAINS domain resets in ascending order once PLL lock is stable,
// and records the cause and count of runtime resets.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS   = 2,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned GAP_CYCLES    = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pll_locked,
    input  logic                     sw_reset,
    input  logic                     wdt_reset,
    output logic [NUM_DOMAINS-1:0]   domain_reset,
    output logic                     ready,
    output logic [1:0]               cause,
    output logic [RESET_COUNT_W-1:0] reset_count
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1)    ? $clog2(GAP_CYCLES)    : 1;
    localparam int unsigned IDX_W = (NUM_DOMAINS > 1)   ? $clog2(NUM_DOMAINS)   : 1;

    logic lock_s;

    reset_seq_lock_sync u_lock_sync (
        .clk_i   (clock),
        .rst_i   (reset),
        .async_i (pll_locked),
        .sync_o  (lock_s)
    );

    state_e                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [GAP_W-1:0]         gap_q;
    logic [IDX_W-1:0]         idx_q;
    logic [NUM_DOMAINS-1:0]   domain_reset_q;
    logic                     ready_q;
    logic [1:0]               cause_q;
    logic [RESET_COUNT_W-1:0] reset_count_q;

    logic                     fault;
    logic [1:0]               cause_d;
    logic [RESET_COUNT_W-1:0] reset_count_d;

    always_comb begin
        fault = ((state_q == RELEASE) || (state_q == RUN)) &&
                (!lock_s || wdt_reset || sw_reset);

        if (!lock_s) begin
            cause_d = CAUSE_LOCK_LOSS;
        end else if (wdt_reset) begin
            cause_d = CAUSE_WDT;
        end else begin
            cause_d = CAUSE_SW;
        end

        reset_count_d = (reset_count_q == '1) ? reset_count_q : reset_count_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= '0;
            gap_q          <= '0;
            idx_q          <= '0;
            domain_reset_q <= '1;
            ready_q        <= 1'b0;
            cause_q        <= CAUSE_POWER;
            reset_count_q  <= '0;
        end else if (fault) begin
            // Fault takes precedence over a release due on the same edge.
            state_q        <= WAIT_LOCK;
            domain_reset_q <= '1;
            ready_q        <= 1'b0;
            cause_q        <= cause_d;
            reset_count_q  <= reset_count_d;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    domain_reset_q <= '1;
                    ready_q        <= 1'b0;
                    if (lock_s && !sw_reset && !wdt_reset) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                    end else if (sw_reset || wdt_reset) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                        state_q <= RELEASE;
                        gap_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                domain_reset_q[k] <= 1'b0;
                            end
                        end
                        gap_q <= '0;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                            ready_q <= 1'b1;
                            state_q <= RUN;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                RUN: begin
                    domain_reset_q <= '0;
                end
                default: begin
                    state_q <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign domain_reset = domain_reset_q;
    assign ready        = ready_q;
    assign cause        = cause_q;
    assign reset_count  = reset_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_DOMAINS=2, STABLE_CYCLES=4, GAP_CYCLES=2.
module tb_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       sw_reset;
    logic       wdt_reset;
    logic [1:0] domain_reset;
    logic       ready;
    logic [1:0] cause;
    logic [7:0] reset_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clock = ~clock;

    reset_sequencer #(
        .NUM_DOMAINS   (2),
        .STABLE_CYCLES (4),
        .GAP_CYCLES    (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .sw_reset     (sw_reset),
        .wdt_reset    (wdt_reset),
        .domain_reset (domain_reset),
        .ready        (ready),
        .cause        (cause),
        .reset_count  (reset_count)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] dr, input logic rdy,
                                 input logic [1:0] cs, input logic [7:0] cnt);
        check_value({tag, " domain_reset"}, 32'(domain_reset), 32'(dr));
        check_value({tag, " ready"},        32'(ready),        32'(rdy));
        check_value({tag, " cause"},        32'(cause),        32'(cs));
        check_value({tag, " reset_count"},  32'(reset_count),  32'(cnt));
    endtask

    // Advance n active edges; returns 1 time unit after the last one.
    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;
        sw_reset   = 1'b0;
        wdt_reset  = 1'b0;
        tick(3);
        check_outputs("reset", 2'b11, 1'b0, 2'd0, 8'd0);
        reset = 1'b0;

        // Lock rises at edge n, drops for one sample at n+3 (STABLE cnt=2), returns at r=n+4.
        pll_locked = 1'b1;
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        tick(4);
        check_outputs("drop r+4", 2'b11, 1'b0, 2'd0, 8'd0);
        tick(3);
        check_outputs("drop r+7", 2'b11, 1'b0, 2'd0, 8'd0);
        tick(1);
        check_outputs("drop r+8", 2'b10, 1'b0, 2'd0, 8'd0);
        tick(1);
        check_outputs("drop r+9", 2'b10, 1'b0, 2'd0, 8'd0);
        tick(1);
        check_outputs("drop r+10", 2'b00, 1'b1, 2'd0, 8'd0);

        // Lock loss in RUN: sampled low at e, response after e+2.
        pll_locked = 1'b0;
        tick(1);
        check_outputs("lockloss e", 2'b00, 1'b1, 2'd0, 8'd0);
        tick(1);
        check_outputs("lockloss e+1", 2'b00, 1'b1, 2'd0, 8'd0);
        tick(1);
        check_outputs("lockloss e+2", 2'b11, 1'b0, 2'd1, 8'd1);
        pll_locked = 1'b1;
        tick(8);
        check_outputs("relock n+7", 2'b11, 1'b0, 2'd1, 8'd1);
        tick(1);
        check_outputs("relock n+8", 2'b10, 1'b0, 2'd1, 8'd1);
        tick(2);
        check_outputs("relock n+10", 2'b00, 1'b1, 2'd1, 8'd1);

        // One-cycle software reset in RUN.
        sw_reset = 1'b1;
        tick(1);
        sw_reset = 1'b0;
        check_outputs("sw m", 2'b11, 1'b0, 2'd3, 8'd2);
        tick(6);
        check_outputs("sw m+6", 2'b11, 1'b0, 2'd3, 8'd2);
        tick(1);
        check_outputs("sw m+7", 2'b10, 1'b0, 2'd3, 8'd2);
        tick(1);
        check_outputs("sw m+8", 2'b10, 1'b0, 2'd3, 8'd2);

        // SW+WDT with lock falling, on the edge domain 1 would be released.
        sw_reset   = 1'b1;
        wdt_reset  = 1'b1;
        pll_locked = 1'b0;
        tick(1);
        check_outputs("wdt+sw f", 2'b11, 1'b0, 2'd2, 8'd3);
        wdt_reset  = 1'b0;
        pll_locked = 1'b1;
        tick(18);
        check_outputs("sw hold f+18", 2'b11, 1'b0, 2'd2, 8'd3);
        tick(1);
        sw_reset = 1'b0;
        tick(4);
        check_outputs("sw drop f+23", 2'b11, 1'b0, 2'd2, 8'd3);
        tick(2);
        check_outputs("sw drop f+25", 2'b11, 1'b0, 2'd2, 8'd3);
        tick(1);
        check_outputs("sw drop f+26", 2'b10, 1'b0, 2'd2, 8'd3);
        tick(2);
        check_outputs("sw drop f+28", 2'b00, 1'b1, 2'd2, 8'd3);

        // 300 watchdog faults, each landing on the first RELEASE cycle.
        for (int i = 0; i < 300; i++) begin
            wdt_reset = 1'b1;
            tick(1);
            wdt_reset = 1'b0;
            if (i == 99) begin
                check_outputs("wdt x100", 2'b11, 1'b0, 2'd2, 8'd103);
            end
            if (i == 252) begin
                check_outputs("wdt sat", 2'b11, 1'b0, 2'd2, 8'd255);
            end
            tick(5);
        end
        check_outputs("wdt x300", 2'b11, 1'b0, 2'd2, 8'd255);

        // Synchronous reset in the middle of RELEASE.
        tick(2);
        check_outputs("mid release", 2'b10, 1'b0, 2'd2, 8'd255);
        reset = 1'b1;
        tick(1);
        check_outputs("reset mid release", 2'b11, 1'b0, 2'd0, 8'd0);
        reset = 1'b0;
        tick(3);
        check_outputs("post reset", 2'b11, 1'b0, 2'd0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Single-clock reset sequencer for the board-level reset tree. It runs on the always-on clock downstream of the board reset hold logic, monitors PLL lock plus software and watchdog reset requests, and releases `NUM_DOMAINS` downstream domain resets one at a time in ascending index order with a programmable gap between releases. It records the cause of the last reset and a saturating count of runtime resets for debug readout.

## Interface
- `NUM_DOMAINS`, default 2: number of sequenced domain resets; must be at least 1.
- `STABLE_CYCLES`, default 256: number of consecutive cycles synchronized lock must stay high before release starts; must be at least 1.
- `GAP_CYCLES`, default 16: cycles between successive domain releases; must be at least 1.
- `clock`  in  1: sole clock.
- `reset`  in  1: synchronous, active-high; all state is initialised on a `clock` edge where `reset`=1.
- `pll_locked`  in  1: asynchronous PLL lock; synchronized internally.
- `sw_reset`  in  1: software reset request, synchronous to `clock`, level-sensitive.
- `wdt_reset`  in  1: watchdog expiry, synchronous to `clock`, level-sensitive.
- `domain_reset`  out  `NUM_DOMAINS`: active-high domain resets; bit k is domain k.
- `ready`  out  1: high when every domain is out of reset.
- `cause`  out  2: cause of the last reset. 0 = POWER, 1 = LOCK_LOSS, 2 = WDT, 3 = SW.
- `reset_count`  out  8: number of runtime resets; saturates at 255.

## Operation
- `lock_s` is `pll_locked` passed through a 2-flop synchronizer. Synchronizer flops reset to 0.
- The FSM has four states: WAIT_LOCK, STABLE, RELEASE, RUN.
- **WAIT_LOCK:** all `domain_reset` bits are 1 and `ready` is 0. When `lock_s`=1 and neither request is high, go to STABLE with `cnt`=0.
- **STABLE:**
  - If `lock_s`=0, go to WAIT_LOCK.
  - Otherwise, if `sw_reset` or `wdt_reset` is high, set `cnt` to 0 and stay. `cause` and `reset_count` do not change; a held request keeps the system in reset.
  - Otherwise, if `cnt`==`STABLE_CYCLES`-1, go to RELEASE with `gap`=0 and `idx`=0.
  - Otherwise, increment `cnt`.
- **RELEASE:** each cycle, increment `gap`. When `gap`==`GAP_CYCLES`-1:
  - clear `domain_reset[idx]`;
  - set `gap` to 0 and increment `idx`;
  - if `idx`==`NUM_DOMAINS`-1, also set `ready` to 1 and go to RUN.
- **RUN:** hold all domains released.
- **Fault:** applies in RELEASE or RUN only. It is triggered when `lock_s`=0, `wdt_reset`=1 or `sw_reset`=1. On the same edge:
  - all `domain_reset` bits go to 1 and `ready` goes to 0;
  - state goes to WAIT_LOCK;
  - `reset_count` increments, saturating at 255;
  - `cause` is latched with priority LOCK_LOSS > WDT > SW.
- Domains already released are re-asserted together. There is no reverse sequencing.
- **Reset values:** `domain_reset` all 1; `ready` 0; `cause` 0 (POWER); `reset_count` 0; state WAIT_LOCK; `cnt`, `gap`, `idx` 0.
- Assertion of `reset` at any point, including mid-RELEASE, returns everything to the reset values on that edge.
- Counter widths are `$clog2` of the bound, with a minimum of 1 bit.

## Timing
- All outputs are registered. Outputs never combinationally depend on inputs.
- Let edge n be the first edge that samples `pll_locked`=1.
  - `lock_s`=1 after edge n+1.
  - STABLE is entered at edge n+2.
  - RELEASE is entered at edge n+2+`STABLE_CYCLES`.
  - `domain_reset[k]` falls at edge n+2+`STABLE_CYCLES`+(k+1)·`GAP_CYCLES`.
  - `ready` rises on the same edge as the last domain.
- `sw_reset` or `wdt_reset` sampled high at edge m, in RELEASE or RUN: domains are asserted after edge m, a 1-cycle response.
- `pll_locked` falling: response is 3 edges later, due to the synchronizer.
- Simultaneous fault and release at the same edge: the fault wins; no bit is cleared.
- Lock returning while in WAIT_LOCK restarts the full STABLE count.

## Structure
- Package `reset_seq_pkg` holds:
  - the state enum (WAIT_LOCK, STABLE, RELEASE, RUN);
  - the cause codes `CAUSE_POWER`, `CAUSE_LOCK_LOSS`, `CAUSE_WDT`, `CAUSE_SW`;
  - the `reset_count` width constant, 8.
- Sub-module `reset_seq_lock_sync`: 2-flop synchronizer with synchronous reset to 0. The FSM, counters and output registers live in `reset_sequencer`.

## Test plan
- Parameters `NUM_DOMAINS`=2, `STABLE_CYCLES`=4, `GAP_CYCLES`=2. Raise `pll_locked` at edge n -> `domain_reset` goes 11→10 at n+8, then 00 at n+10. `ready`=1 at n+10. `cause`=0, `reset_count`=0.
- Drop `pll_locked` for 1 cycle at STABLE `cnt`=2 -> return to WAIT_LOCK. Release occurs 8 edges after the re-rise. `reset_count` stays 0.
- In RUN, pulse `sw_reset` 1 cycle -> `domain_reset`=11 and `ready`=0 next cycle, `cause`=3, `reset_count`=1. Full re-sequence follows.
- Assert `sw_reset` and `wdt_reset` together while `pll_locked` falls, during RELEASE after domain 0 is released -> `domain_reset`=11, `cause`=2 (WDT beats SW, since `lock_s` is still high). Hold `sw_reset` for 20 cycles -> no release until 4 cycles of STABLE after it drops.
- Force 300 watchdog faults -> `reset_count` holds at 255.
- Assert `reset` mid-RELEASE -> all outputs at reset values on that edge, `cause`=0.
